// File: rtl/dev_reshuffler_fifo.sv
// Per-beat matrix reorder (pass / transpose / row-reverse) feeding a Depth-entry
// output FIFO with registered-only ready and valid.
module dev_reshuffler_fifo #(
    parameter int unsigned SpatPar   = 8,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ElemWidth = DataWidth / SpatPar,
    parameter int unsigned Depth     = 2,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [SpatPar*DataWidth-1:0] a_i,
    input  logic [1:0]                   a_mode_i,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    output logic [SpatPar*DataWidth-1:0] z_o,
    output logic                         z_valid_o,
    input  logic                         z_ready_i,
    output logic [CntWidth-1:0]          count_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned Width    = SpatPar * DataWidth;

    typedef enum logic [1:0] {
        MODE_PASS        = 2'b00,
        MODE_TRANSPOSE   = 2'b01,
        MODE_ROW_REVERSE = 2'b10,
        MODE_RESERVED    = 2'b11
    } mode_t;

    mode_t               mode;
    logic [Width-1:0]    shuffled;
    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                push;
    logic                pop;

    assign mode = mode_t'(a_mode_i);

    always_comb begin
        shuffled = '0;
        for (int unsigned r = 0; r < SpatPar; r++) begin
            for (int unsigned c = 0; c < SpatPar; c++) begin
                unique case (mode)
                    MODE_TRANSPOSE:
                        shuffled[(r*SpatPar+c)*ElemWidth +: ElemWidth] =
                            a_i[(c*SpatPar+r)*ElemWidth +: ElemWidth];
                    MODE_ROW_REVERSE:
                        shuffled[(r*SpatPar+c)*ElemWidth +: ElemWidth] =
                            a_i[((SpatPar-1-r)*SpatPar+c)*ElemWidth +: ElemWidth];
                    default:
                        shuffled[(r*SpatPar+c)*ElemWidth +: ElemWidth] =
                            a_i[(r*SpatPar+c)*ElemWidth +: ElemWidth];
                endcase
            end
        end
    end

    assign a_ready_o = (count != CntWidth'(Depth));
    assign z_valid_o = (count != '0);
    assign z_o       = z_valid_o ? mem[rd_ptr] : '0;
    assign count_o   = count;

    assign push = a_valid_i && a_ready_o;
    assign pop  = z_valid_o && z_ready_i;

    // Storage needs no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= shuffled;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (z_valid_o && !z_ready_i) |=> (z_valid_o && $stable(z_o)));
    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        (count <= CntWidth'(Depth)));
`endif

endmodule

// File: tb/tb_dev_reshuffler_fifo.sv
// Directed and randomized checks of dev_reshuffler_fifo at SpatPar=4, ElemWidth=8, Depth=4.
module tb_dev_reshuffler_fifo;

    localparam int W     = 128;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a;
    logic [1:0]    a_mode;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  z;
    logic          z_valid;
    logic          z_ready;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [$];

    always #5 clk = ~clk;

    dev_reshuffler_fifo #(
        .SpatPar   (4),
        .DataWidth (32),
        .Depth     (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_i       (a),
        .a_mode_i  (a_mode),
        .a_valid_i (a_valid),
        .a_ready_o (a_ready),
        .z_o       (z),
        .z_valid_o (z_valid),
        .z_ready_i (z_ready),
        .count_o   (count)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [1:0]   mode;
        logic [W-1:0] z;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] reshape(input logic [W-1:0] d, input logic [1:0] m);
        logic [7:0]   e [4][4];
        logic [W-1:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                e[r][c] = d[(r*4+c)*8 +: 8];
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                case (m)
                    2'b01:   res[(r*4+c)*8 +: 8] = e[c][r];
                    2'b10:   res[(r*4+c)*8 +: 8] = e[3-r][c];
                    default: res[(r*4+c)*8 +: 8] = e[r][c];
                endcase
        return res;
    endfunction

    // One model-checked cycle: compare outputs against the queue, then clock.
    task automatic cycle(input logic v, input logic r, input logic [W-1:0] d,
                         input logic [1:0] m, output logic pushed);
        logic do_push, do_pop;
        logic [W-1:0] exp_z;
        a = d; a_mode = m; a_valid = v; z_ready = r;
        exp_z = (q.size() != 0) ? q[0] : '0;
        chk("m_a_ready", a_ready, q.size() != DEPTH);
        chk("m_z_valid", z_valid, q.size() != 0);
        chk("m_z", z, exp_z);
        chk("m_count", count, q.size());
        do_push = v && (q.size() != DEPTH);
        do_pop  = r && (q.size() != 0);
        step();
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(reshape(d, m));
        pushed = do_push;
    endtask

    localparam logic [W-1:0] A  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [W-1:0] B  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

    initial begin
        logic [W-1:0] d [5];
        logic [1:0]   md [5];
        logic         pushed;
        logic         hold;
        logic [W-1:0] sd;
        logic [1:0]   sm;
        logic         sv;

        vecs[0] = '{A, 2'b00, A};
        vecs[1] = '{A, 2'b01, 128'h0F0B0703_0E0A0602_0D090501_0C080400};
        vecs[2] = '{A, 2'b10, 128'h03020100_07060504_0B0A0908_0F0E0D0C};
        vecs[3] = '{A, 2'b11, A};
        vecs[4] = '{B, 2'b01, 128'h1F1B1713_1E1A1612_1D191511_1C181410};
        vecs[5] = '{B, 2'b10, 128'h13121110_17161514_1B1A1918_1F1E1D1C};

        rst = 1'b1; a = '0; a_mode = 2'b00; a_valid = 1'b0; z_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_z_valid", z_valid, 1'b0);
        chk("rst_z", z, '0);
        chk("rst_count", count, 3'd0);
        chk("rst_a_ready", a_ready, 1'b1);

        // Single beat per vector: 1-cycle latency, popped on the cycle it appears.
        for (int i = 0; i < 6; i++) begin
            a = vecs[i].a; a_mode = vecs[i].mode; a_valid = 1'b1; z_ready = 1'b1;
            chk("vec_empty_valid", z_valid, 1'b0);
            step();
            a_valid = 1'b0; a = '0;
            chk("vec_z_valid", z_valid, 1'b1);
            chk("vec_z", z, vecs[i].z);
            chk("vec_count", count, 3'd1);
            step();
            chk("vec_popped_count", count, 3'd0);
            chk("vec_popped_z", z, '0);
        end
        z_ready = 1'b0;

        // Fill and back-pressure with a held 5th beat.
        md[0] = 2'b00; md[1] = 2'b01; md[2] = 2'b10; md[3] = 2'b00; md[4] = 2'b01;
        for (int i = 0; i < 5; i++) d[i] = A ^ {16{8'(i * 17)}};
        for (int i = 0; i < 4; i++) begin
            a = d[i]; a_mode = md[i]; a_valid = 1'b1;
            chk("fill_a_ready", a_ready, 1'b1);
            step();
        end
        a = d[4]; a_mode = md[4];
        chk("full_count", count, 3'd4);
        chk("full_a_ready", a_ready, 1'b0);
        step(); step();
        chk("full_hold_count", count, 3'd4);
        chk("full_hold_z", z, reshape(d[0], md[0]));
        z_ready = 1'b1;
        step();
        chk("pop1_count", count, 3'd3);
        chk("pop1_a_ready", a_ready, 1'b1);
        chk("pop1_z", z, reshape(d[1], md[1]));
        step();
        a_valid = 1'b0; a = '0;
        chk("late_push_count", count, 3'd3);
        for (int i = 2; i < 5; i++) begin
            chk("drain_z", z, reshape(d[i], md[i]));
            step();
        end
        chk("drain_count", count, 3'd0);
        chk("drain_z_valid", z_valid, 1'b0);
        z_ready = 1'b0;
        q.delete();

        // Concurrent push/pop at occupancy 2 across pointer wrap.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, B ^ {16{8'(i)}}, 2'(i), pushed);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, A ^ {16{8'(i + 40)}}, 2'(i % 3), pushed);
            chk("conc_count", count, 3'd2);
        end
        while (q.size() != 0) cycle(1'b0, 1'b1, '0, 2'b00, pushed);

        // Reset mid-stream with a beat presented.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, B ^ {16{8'(i + 90)}}, 2'b01, pushed);
        chk("pre_rst_count", count, 3'd3);
        rst = 1'b1; a_valid = 1'b1; a = A; a_mode = 2'b00;
        step();
        rst = 1'b0; a_valid = 1'b0;
        q.delete();
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_z_valid", z_valid, 1'b0);
        chk("mid_rst_z", z, '0);
        chk("mid_rst_a_ready", a_ready, 1'b1);
        step();
        chk("mid_rst_no_store", count, 3'd0);

        // Random soak; an unaccepted beat is held stable by the source.
        hold = 1'b0; sd = '0; sm = 2'b00; sv = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                sd = {$urandom, $urandom, $urandom, $urandom};
                sm = 2'($urandom_range(0, 3));
                sv = 1'($urandom_range(0, 1));
            end
            cycle(sv, 1'($urandom_range(0, 1)), sd, sm, pushed);
            hold = sv && !pushed;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dev_reshuffler_fifo.md
Name: dev_reshuffler_fifo

Overview:
- Parametrised successor to the single-register reshuffler.
- Each input beat is a SpatPar x SpatPar matrix of ElemWidth-bit elements. A per-beat mode (passthrough, transpose, row-reverse) reorders the elements, and the result is written into a Depth-entry output FIFO.
- Both ports use full valid/ready handshakes with no combinational ready-to-ready path. Sits between the streamer read port and the accelerator datapath in dev test systems.

Parameters:
- SpatPar, 8, matrix dimension (rows = cols); must be >= 2.
- DataWidth, 64, bits per row; must be a multiple of SpatPar.
- ElemWidth, DataWidth/SpatPar, bits per element (derived; do not override).
- Depth, 2, output FIFO entries; must be >= 1. Any value is legal, not only powers of 2.
- CntWidth, $clog2(Depth+1), width of the occupancy count (derived).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- a_i  in  SpatPar*DataWidth  input matrix.
- a_mode_i  in  2  reorder mode, sampled together with a_i.
- a_valid_i  in  1  input valid.
- a_ready_o  out  1  input ready.
- z_o  out  SpatPar*DataWidth  output matrix (FIFO head).
- z_valid_o  out  1  output valid.
- z_ready_i  in  1  output ready.
- count_o  out  CntWidth  number of FIFO entries occupied.

Behaviour:
- Element layout (input and output): element (r,c) occupies bits [(r*SpatPar+c)*ElemWidth +: ElemWidth].
- Modes, applied combinationally at the input:
  - 2'b00: pass, z(r,c)=a(r,c).
  - 2'b01: transpose, z(r,c)=a(c,r).
  - 2'b10: row-reverse, z(r,c)=a(SpatPar-1-r,c).
  - 2'b11: reserved; behaves as pass.
- Push = a_valid_i && a_ready_o. Pop = z_valid_o && z_ready_i.
- a_ready_o = (count != Depth). It depends only on registered state, never on z_ready_i.
- z_valid_o = (count != 0).
- z_o = entry at rd_ptr when count != 0, else all zeros.
- count_o = count.
- Push: the reordered word is written at wr_ptr. wr_ptr advances, wrapping from Depth-1 to 0.
- Pop: rd_ptr advances with the same wrap rule.
- Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged, both pointers advance.
- Full (count == Depth): a_ready_o = 0, so a push cannot coincide with the pop. The freed slot is visible as a_ready_o = 1 in the next cycle.
- Empty: there is no bypass. A word pushed at edge N is first presented as z_valid_o = 1 after edge N, so latency is 1 cycle.
- Elements are reordered bit-exact. No arithmetic is performed on elements.
- Ordering: strict FIFO order. Each mode is bound to its own beat, so a mode change between beats does not affect words already queued.
- Reset (rst_i = 1 at an edge):
  - rd_ptr = wr_ptr = count = 0.
  - Outputs: z_valid_o = 0, z_o = 0, count_o = 0, a_ready_o = 1.
  - Storage contents are don't-care.
  - Reset takes priority over a simultaneous push or pop. A mid-stream reset discards all queued words.
- a_valid_i may be asserted while a_ready_o = 0. The beat is not consumed and the source must hold it.
- Protocol assertions:
  - Once z_valid_o is asserted it stays asserted, with z_o unchanged, until a pop.
  - count never exceeds Depth.

Test Plan:
Common setup: SpatPar=4, DataWidth=32 (ElemWidth=8), Depth=4. Input A has byte k = k, i.e. 128'h0F0E0D0C_0B0A0908_07060504_03020100.
- Transpose: push A with mode 01, z_ready_i=1 -> one cycle later z_valid_o=1, z_o=128'h0F0B0703_0E0A0602_0D090501_0C080400, count_o=1. It pops on that cycle.
- Row-reverse and reserved: A with mode 10 -> z_o=128'h03020100_07060504_0B0A0908_0F0E0D0C. A with mode 11 -> z_o=A.
- Fill and back-pressure: z_ready_i=0, push 5 consecutive beats (modes 00,01,10,00,01) -> first 4 accepted, count_o=4, a_ready_o=0. 5th beat held. Raise z_ready_i -> outputs appear in push order with the correct per-beat mode, and the 5th beat is accepted the cycle after the first pop.
- Concurrent push/pop: with count_o=2, assert push and pop every cycle for 10 cycles -> count_o stays 2, data order preserved, pointers wrap with no loss or duplication.
- Reset mid-stream: count_o=3, assert rst_i for 1 cycle while a_valid_i=1 -> next cycle count_o=0, z_valid_o=0, z_o=0, a_ready_o=1. The beat presented during reset is not stored.
- Random soak: random a_valid_i and z_ready_i over 2000 cycles against a scoreboard model -> zero mismatches, no valid-drop violations.
